system_button_debouncer: RTL and testbench



---
 rtl/system_button_pkg.sv | 13 +
 rtl/system_debounce_channel.sv | 70 +++++++
 rtl/system_button_debouncer.sv | 53 +++++
 tb/tb_system_button_debouncer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_button_pkg.sv
// Shared types and default constants for the push-button debouncer.
package system_button_pkg;

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_FILTER = 1'b1
    } btn_state_e;

    localparam int BTN_WIDTH          = 5;
    localparam int BTN_PRESCALE       = 50000;
    localparam int BTN_DEBOUNCE_TICKS = 20;

endpackage

// File: rtl/system_debounce_channel.sv
// One button channel: two-flop synchroniser, tick-based debounce filter and
// registered press/release strobes.
//
// state     | meaning
// ST_STABLE | synchronised pad equals debounced level, cnt held at 0
// ST_FILTER | pad differs from debounced level, counting persistent ticks
module system_debounce_channel
    import system_button_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS,
    parameter logic RESET_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync_q1;
    logic             sync_q2;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_cur;

    // The tick that first sees the mismatch already counts toward the filter,
    // so a STABLE channel starts its count from zero on that same cycle.
    assign cnt_cur = (state == ST_STABLE) ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1       <= RESET_LEVEL;
            sync_q2       <= RESET_LEVEL;
            btn_out       <= RESET_LEVEL;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            cnt           <= '0;
            state         <= ST_STABLE;
        end else begin
            sync_q1       <= btn_raw;
            sync_q2       <= sync_q1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync_q2 == btn_out) begin
                cnt   <= '0;
                state <= ST_STABLE;
            end else if (tick) begin
                if (cnt_cur == CNT_LAST) begin
                    btn_out       <= sync_q2;
                    cnt           <= '0;
                    state         <= ST_STABLE;
                    press_pulse   <= (sync_q2 != RESET_LEVEL);
                    release_pulse <= (sync_q2 == RESET_LEVEL);
                end else begin
                    cnt   <= cnt_cur + CNT_W'(1);
                    state <= ST_FILTER;
                end
            end else begin
                cnt   <= cnt_cur;
                state <= ST_FILTER;
            end
        end
    end

endmodule

// File: rtl/system_button_debouncer.sv
// Debounces WIDTH active-low push-button pads for the button PIO in_port,
// with a single shared tick prescaler driving every channel filter.
module system_button_debouncer
    import system_button_pkg::*;
#(
    parameter int   WIDTH          = BTN_WIDTH,
    parameter int   PRESCALE       = BTN_PRESCALE,
    parameter int   DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS,
    parameter logic RESET_LEVEL    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    // With PRESCALE=1 the counter never leaves 0, so tick is constantly high.
    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        system_debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .tick          (tick),
            .btn_raw       (btn_raw[i]),
            .btn_out       (btn_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_system_button_debouncer.sv
// Bench for system_button_debouncer: two configurations checked every cycle
// against a persistence-rule model, plus directed latency and bounce cases.
module tb_system_button_debouncer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] out_a, press_a, rel_a;
    logic [4:0] out_b, press_b, rel_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    system_button_debouncer #(
        .WIDTH(5), .PRESCALE(1), .DEBOUNCE_TICKS(4), .RESET_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_out(out_a), .press_pulse(press_a), .release_pulse(rel_a)
    );

    system_button_debouncer #(
        .WIDTH(5), .PRESCALE(3), .DEBOUNCE_TICKS(2), .RESET_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_out(out_b), .press_pulse(press_b), .release_pulse(rel_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a level is accepted once the synchronised pad has differed
    // from the debounced output on DEBOUNCE_TICKS consecutive tick cycles
    // without ever matching it in between.
    int         m_p[2] = '{1, 3};
    int         m_d[2] = '{4, 2};
    logic [4:0] m_s1[2], m_s2[2], m_out[2], m_press[2], m_rel[2];
    int         m_run[2][5];
    int         m_cyc[2];
    bit         model_ok = 1'b0;

    always @(posedge clk) begin : model
        bit tk;
        for (int c = 0; c < 2; c++) begin
            if (!reset_n) begin
                m_s1[c] = 5'h1f; m_s2[c] = 5'h1f; m_out[c] = 5'h1f;
                m_press[c] = '0; m_rel[c] = '0; m_cyc[c] = 0;
                for (int i = 0; i < 5; i++) m_run[c][i] = 0;
            end else begin
                tk = ((m_cyc[c] % m_p[c]) == m_p[c] - 1);
                m_cyc[c]++;
                m_press[c] = '0;
                m_rel[c]   = '0;
                for (int i = 0; i < 5; i++) begin
                    if (m_s2[c][i] == m_out[c][i]) begin
                        m_run[c][i] = 0;
                    end else if (tk) begin
                        m_run[c][i]++;
                        if (m_run[c][i] >= m_d[c]) begin
                            m_out[c][i] = m_s2[c][i];
                            if (m_out[c][i] == 1'b0) m_press[c][i] = 1'b1;
                            else                     m_rel[c][i]   = 1'b1;
                            m_run[c][i] = 0;
                        end
                    end
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = btn_raw;
            end
        end
        if (!reset_n) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check_val("a_out",   out_a,   m_out[0]);
            check_val("a_press", press_a, m_press[0]);
            check_val("a_rel",   rel_a,   m_rel[0]);
            check_val("b_out",   out_b,   m_out[1]);
            check_val("b_press", press_b, m_press[1]);
            check_val("b_rel",   rel_b,   m_rel[1]);
            check_val("a_excl",  press_a & rel_a, 5'h00);
            check_val("b_excl",  press_b & rel_b, 5'h00);
        end
    end

    int n;
    bit done;
    logic any2;
    int hold[5];

    initial begin
        reset_n = 1'b0;
        btn_raw = 5'h1f;
        repeat (3) @(negedge clk);
        check_val("rst_out", out_a, 5'h1f);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("idle_out", out_a, 5'h1f);

        // PRESCALE=3 / DT=2: press released together with reset exit.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        btn_raw[0] = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(posedge clk); #1; n++;
            if (out_b[0] == 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        check_val("b_press_lat", n, 6);
        check_val("b_press_pulse", press_b, 5'h01);

        // Same, with a one-cycle bounce after the first counted tick.
        @(negedge clk);
        btn_raw = 5'h1f;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        btn_raw[0] = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(posedge clk); #1; n++;
            if (out_b[0] == 1'b0) done = 1'b1;
            else begin
                @(negedge clk);
                if (n == 3) btn_raw[0] = 1'b1;
                if (n == 4) btn_raw[0] = 1'b0;
            end
        end
        check_val("b_bounce_lat", n, 12);

        // PRESCALE=1 / DT=4: press on channel 0.
        @(negedge clk);
        btn_raw = 5'h1f;
        repeat (20) @(negedge clk);
        btn_raw[0] = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(posedge clk); #1; n++;
            if (out_a[0] == 1'b0) done = 1'b1;
        end
        check_val("a_press_lat", n, 6);
        check_val("a_press_pulse", press_a, 5'h01);
        check_val("a_press_rel", rel_a, 5'h00);
        @(negedge clk);

        // Channel 2 chatter shorter than the filter window.
        any2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            btn_raw[2] = ((k / 2) % 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            any2 = any2 | press_a[2] | rel_a[2] | ~out_a[2];
        end
        btn_raw[2] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            any2 = any2 | press_a[2] | rel_a[2] | ~out_a[2];
        end
        check_val("a_chatter2", any2, 1'b0);

        // Channels 1 and 4: press, then release on the same cycle.
        btn_raw[1] = 1'b0; btn_raw[4] = 1'b0;
        repeat (12) @(negedge clk);
        btn_raw[1] = 1'b1; btn_raw[4] = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(posedge clk); #1; n++;
            if (out_a[1] == 1'b1) done = 1'b1;
        end
        check_val("a_rel_lat", n, 6);
        check_val("a_rel_pulse", rel_a, 5'h12);
        check_val("a_rel_out", out_a, 5'h1e);
        @(negedge clk);

        // Reset mid-filter on channel 3 (cnt=2 after four edges).
        btn_raw[3] = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("a_rst_mid_out", out_a, 5'h1f);
        reset_n = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(posedge clk); #1; n++;
            if (out_a[3] == 1'b0) done = 1'b1;
        end
        check_val("a_rst_relat", n, 6);
        @(negedge clk);

        // Randomised chatter and long holds on every channel.
        for (int i = 0; i < 5; i++) hold[i] = $urandom_range(1, 12);
        for (int k = 0; k < 3000; k++) begin
            reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 5; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(10, 20)
                                                          : $urandom_range(1, 6);
                end
            end
            @(negedge clk);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
